// File: rtl/card_dealer.sv
// card_dealer: card source for the bell game; deals two cards per round
// and runs the per-round score countdown.
// Ports: clk, rst (sync, active-high), start, finish in.
//        c1/c2 colours, n1/n2 numbers, count, card_valid, round_no,
//        game_over out. All outputs are registered.
module card_dealer #(
    parameter logic [7:0]  COUNT_INIT = 8'd100,
    parameter int          TICK_DIV   = 1000,
    parameter int          GAP_CYCLES = 500,
    parameter logic [7:0]  ROUNDS     = 8'd20,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       finish,
    output logic [1:0] c1,
    output logic [1:0] c2,
    output logic [2:0] n1,
    output logic [2:0] n2,
    output logic [7:0] count,
    output logic       card_valid,
    output logic [7:0] round_no,
    output logic       game_over
);

    localparam logic [15:0] SEED =
        (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam int TW = $clog2(TICK_DIV);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DEAL, S_SHOW, S_GAP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1:0]    c1_q, c1_d, c2_q, c2_d;
    logic [2:0]    n1_q, n1_d, n2_q, n2_d;
    logic [7:0]    count_q, count_d;
    logic          valid_q, valid_d;
    logic [7:0]    round_q, round_d;
    logic          over_q, over_d;

    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        tick_d  = tick_q;
        gap_d   = gap_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
        count_d = count_q;
        valid_d = valid_q;
        round_d = round_q;
        over_d  = over_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_DEAL;
            end
            S_DEAL: begin
                c1_d    = lfsr_q[1:0];
                n1_d    = 3'd1 + (lfsr_q[4:2] % 3'd5);
                c2_d    = lfsr_q[6:5];
                n2_d    = 3'd1 + (lfsr_q[9:7] % 3'd5);
                count_d = COUNT_INIT;
                valid_d = 1'b1;
                round_d = round_q + 8'd1;
                tick_d  = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (finish) begin
                    // finish wins over a same-cycle tick
                    state_d = S_GAP;
                    gap_d   = '0;
                    valid_d = 1'b0;
                    count_d = 8'd0;
                    c1_d    = 2'd0;
                    c2_d    = 2'd0;
                    n1_d    = 3'd0;
                    n2_d    = 3'd0;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    // last tick at count 1: redeal, cards stay up
                    if (count_q <= 8'd1) state_d = S_DEAL;
                    else count_d = count_q - 8'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (round_q == ROUNDS) begin
                        state_d = S_DONE;
                        over_d  = 1'b1;
                    end else begin
                        state_d = S_DEAL;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    round_d = 8'd0;
                    over_d  = 1'b0;
                    state_d = S_DEAL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            tick_q  <= '0;
            gap_q   <= '0;
            c1_q    <= 2'd0;
            c2_q    <= 2'd0;
            n1_q    <= 3'd0;
            n2_q    <= 3'd0;
            count_q <= 8'd0;
            valid_q <= 1'b0;
            round_q <= 8'd0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            count_q <= count_d;
            valid_q <= valid_d;
            round_q <= round_d;
            over_q  <= over_d;
        end
    end

    assign c1         = c1_q;
    assign c2         = c2_q;
    assign n1         = n1_q;
    assign n2         = n2_q;
    assign count      = count_q;
    assign card_valid = valid_q;
    assign round_no   = round_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: randomized bench for card_dealer with an
// event-level reference model and per-cycle output comparison.
module tb_card_dealer;

    localparam logic [7:0]  INIT = 8'd10;
    localparam int          TD   = 4;
    localparam int          GAP  = 5;
    localparam logic [7:0]  RND  = 8'd2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       finish = 1'b0;
    logic [1:0] c1, c2;
    logic [2:0] n1, n2;
    logic [7:0] count, round_no;
    logic       card_valid, game_over;

    int checks = 0;
    int passes = 0;

    card_dealer #(
        .COUNT_INIT(INIT),
        .TICK_DIV  (TD),
        .GAP_CYCLES(GAP),
        .ROUNDS    (RND),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .finish    (finish),
        .c1        (c1),
        .c2        (c2),
        .n1        (n1),
        .n2        (n2),
        .count     (count),
        .card_valid(card_valid),
        .round_no  (round_no),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_DEAL, M_SHOW, M_HIDE, M_OVER} mph_t;
    mph_t        m_ph = M_IDLE;
    logic [15:0] m_lfsr = SEED;
    logic [1:0]  mc1 = 2'd0, mc2 = 2'd0;
    logic [2:0]  mn1 = 3'd0, mn2 = 3'd0;
    logic [7:0]  m_round = 8'd0;
    bit          m_shown = 1'b0;
    int          m_age = 0;
    int          m_hid = 0;
    int          m_deals = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic model_step(input logic r, input logic s,
                              input logic f);
        logic [15:0] l;
        l = m_lfsr;
        m_lfsr = r ? SEED : lfsr_next(l);
        if (r) begin
            m_ph = M_IDLE;
            m_shown = 1'b0;
            m_round = 8'd0;
            m_age = 0;
            m_hid = 0;
        end else begin
            case (m_ph)
                M_IDLE: if (s) m_ph = M_DEAL;
                M_DEAL: begin
                    mc1 = l[1:0];
                    mn1 = 3'(1 + int'(l[4:2]) % 5);
                    mc2 = l[6:5];
                    mn2 = 3'(1 + int'(l[9:7]) % 5);
                    m_shown = 1'b1;
                    m_age = 0;
                    m_round = m_round + 8'd1;
                    m_deals++;
                    m_ph = M_SHOW;
                end
                M_SHOW: begin
                    if (f) begin
                        m_ph = M_HIDE;
                        m_shown = 1'b0;
                        m_hid = 0;
                    end else if (m_age + 1 == TD * int'(INIT)) begin
                        m_ph = M_DEAL;
                    end else begin
                        m_age++;
                    end
                end
                M_HIDE: begin
                    m_hid++;
                    if (m_hid == GAP)
                        m_ph = (m_round == RND) ? M_OVER : M_DEAL;
                end
                M_OVER: begin
                    if (s) begin
                        m_round = 8'd0;
                        m_ph = M_DEAL;
                    end
                end
                default: m_ph = M_IDLE;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_outs();
        logic [7:0] cnt;
        logic       ov;
        ov = (m_ph == M_OVER);
        cnt = INIT - 8'(m_age / TD);
        if (m_shown)
            return {4'b0, mc1, mc2, mn1, mn2, cnt, 1'b1, m_round, ov};
        return {4'b0, 10'b0, 8'b0, 1'b0, m_round, ov};
    endfunction

    function automatic logic [31:0] outs();
        return {4'b0, c1, c2, n1, n2, count, card_valid,
                round_no, game_over};
    endfunction

    initial forever begin
        @(posedge clk);
        model_step(rst, start, finish);
    end

    // ---------------- per-cycle comparison ----------------
    initial forever begin
        @(negedge clk);
        checks++;
        if (outs() === exp_outs()) passes++;
        else $display("FAIL outputs got=%h exp=%h t=%0t",
                      outs(), exp_outs(), $time);
        checks++;
        if (card_valid === 1'b1 ?
            (n1 >= 3'd1 && n1 <= 3'd5 && n2 >= 3'd1 && n2 <= 3'd5) :
            (n1 === 3'd0 && n2 === 3'd0 &&
             c1 === 2'd0 && c2 === 2'd0 && count === 8'd0))
            passes++;
        else $display("FAIL card_range valid=%b n1=%0d n2=%0d c1=%0d c2=%0d t=%0t",
                      card_valid, n1, n2, c1, c2, $time);
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int ncyc;
        int target;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        chk("reset_zero", int'(outs()), 0);

        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        chk("deal1_valid", int'(card_valid), 1);
        chk("deal1_count", int'(count), 10);
        chk("deal1_round", int'(round_no), 1);
        cyc(4);
        chk("tick1_count", int'(count), 9);
        cyc(4);
        chk("tick2_count", int'(count), 8);
        cyc(4);
        chk("tick3_count", int'(count), 7);
        cyc(3);
        chk("pre_finish_count", int'(count), 7);
        finish = 1'b1;
        cyc(1);
        finish = 1'b0;
        chk("finish_valid", int'(card_valid), 0);
        chk("finish_count", int'(count), 0);
        cyc(GAP);
        chk("gap_hidden", int'(card_valid), 0);
        cyc(1);
        chk("deal2_valid", int'(card_valid), 1);
        chk("deal2_count", int'(count), 10);
        chk("deal2_round", int'(round_no), 2);

        finish = 1'b1;
        cyc(1);
        finish = 1'b0;
        cyc(GAP);
        chk("game_over_set", int'(game_over), 1);
        chk("game_over_round", int'(round_no), 2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("game_over_clr", int'(game_over), 0);
        cyc(1);
        chk("restart_round", int'(round_no), 1);
        chk("restart_count", int'(count), 10);

        cyc(TD * int'(INIT) - 1);
        chk("timeout_min", int'(count), 1);
        cyc(2);
        chk("redeal_count", int'(count), 10);
        chk("redeal_round", int'(round_no), 2);
        chk("redeal_valid", int'(card_valid), 1);

        rst = 1'b1;
        cyc(1);
        chk("midshow_rst", int'(outs()), 0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        chk("post_rst_idle", int'(outs()), 0);

        ncyc = 0;
        target = m_deals + 1000;
        while (m_deals < target && ncyc < 60000) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) == 0);
            finish = ($urandom_range(0, 19) == 0);
            rst    = ($urandom_range(0, 2999) == 0);
            ncyc++;
        end
        start = 1'b0;
        finish = 1'b0;
        rst = 1'b0;
        cyc(2);
        checks++;
        if (m_deals >= target) passes++;
        else $display("FAIL random_deals got=%0d exp=%0d",
                      m_deals, target);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
